// File: rtl/branch_stack_pkg.sv
// rtl/branch_stack_pkg.sv - sizes, checkpoint types and helpers shared by the branch stack
package branch_stack_pkg;

   localparam int DEPTH           = 4;
   localparam int PHYS_REG_SZ     = 64;
   localparam int PHYS_REG_IDX    = $clog2(PHYS_REG_SZ);
   localparam int ARCH_REG_SZ     = 32;
   localparam int ROB_SZ          = 32;
   localparam int ROB_IDX_W       = $clog2(ROB_SZ);
   localparam int RETIRE_W        = 2;
   localparam int NUM_SCALAR_BITS = $clog2(RETIRE_W + 1);
   localparam int MAP_W           = ARCH_REG_SZ * PHYS_REG_IDX;
   localparam int RETIRE_BUS_W    = RETIRE_W * PHYS_REG_IDX;

   typedef logic [DEPTH-1:0]        branch_mask_t;
   typedef logic [PHYS_REG_SZ-1:0]  free_list_t;
   typedef logic [MAP_W-1:0]        map_table_t;
   typedef logic [ROB_IDX_W-1:0]    rob_idx_t;
   typedef logic [RETIRE_BUS_W-1:0] retire_bus_t;

   typedef struct packed {
      free_list_t   free_list;
      map_table_t   map_table;
      rob_idx_t     rob_tail;
      branch_mask_t dep_mask;
   } branch_checkpoint_t;

   // Registers freed by this cycle's retirements, as a free-list-shaped mask.
   function automatic free_list_t retire_fold(input retire_bus_t regs,
                                              input logic [NUM_SCALAR_BITS-1:0] num);
      free_list_t m;
      m = '0;
      for (int i = 0; i < RETIRE_W; i++) begin
         if (i < int'(num)) begin
            m[regs[i*PHYS_REG_IDX +: PHYS_REG_IDX]] = 1'b1;
         end
      end
      return m;
   endfunction

   function automatic logic is_onehot(input branch_mask_t m);
      return (m != '0) && ((m & (m - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/branch_stack_if.sv
// rtl/branch_stack_if.sv - dispatch / retire / resolve / restore signal bundle of the branch stack
interface branch_stack_if;
   import branch_stack_pkg::*;

   logic         dispatch_valid;
   free_list_t   dispatch_free_list;
   map_table_t   dispatch_map_table;
   rob_idx_t     dispatch_rob_tail;
   logic         dispatch_ready;
   branch_mask_t dispatch_mask;
   branch_mask_t branch_mask;

   retire_bus_t                phys_reg_retiring;
   logic [NUM_SCALAR_BITS-1:0] num_retiring_valid;

   logic         resolve_valid;
   branch_mask_t resolve_mask;
   logic         resolve_mispredict;

   logic         restore_flag;
   free_list_t   free_list_restore;
   map_table_t   map_table_restore;
   rob_idx_t     rob_tail_restore;
   branch_mask_t resolve_clear_mask;

   modport master (
      output dispatch_valid, dispatch_free_list, dispatch_map_table, dispatch_rob_tail,
      output phys_reg_retiring, num_retiring_valid,
      output resolve_valid, resolve_mask, resolve_mispredict,
      input  dispatch_ready, dispatch_mask, branch_mask,
      input  restore_flag, free_list_restore, map_table_restore, rob_tail_restore,
      input  resolve_clear_mask
   );

   modport slave (
      input  dispatch_valid, dispatch_free_list, dispatch_map_table, dispatch_rob_tail,
      input  phys_reg_retiring, num_retiring_valid,
      input  resolve_valid, resolve_mask, resolve_mispredict,
      output dispatch_ready, dispatch_mask, branch_mask,
      output restore_flag, free_list_restore, map_table_restore, rob_tail_restore,
      output resolve_clear_mask
   );

endinterface

// File: rtl/branch_slot_alloc.sv
// rtl/branch_slot_alloc.sv - picks the lowest-index free checkpoint slot as a one-hot grant
module branch_slot_alloc #(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0] busy,
   output logic [DEPTH-1:0] grant
);

   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!busy[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/branch_stack.sv
// rtl/branch_stack.sv - branch checkpoint stack with retire folding and mispredict restore
// Optional BRANCH_STACK_STATS_EN adds saturating mispredict/correct resolve counters.
module branch_stack
   import branch_stack_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   branch_stack_if.slave bs
`ifdef BRANCH_STACK_STATS_EN
   ,
   output logic [31:0]   num_mispredicts,
   output logic [31:0]   num_correct
`endif
);

   branch_mask_t       valid_q;
   branch_mask_t       valid_d;
   branch_checkpoint_t slot_q [DEPTH];

   free_list_t   retire_mask;
   branch_mask_t alloc_onehot;
   branch_mask_t squash;
   logic         dispatch_ready_w;
   logic         res_ok;
   logic         res_mis;
   logic         res_cor;
   logic         push;

   free_list_t   res_free_list;
   map_table_t   res_map_table;
   rob_idx_t     res_rob_tail;

   logic         restore_flag_q;
   free_list_t   free_list_restore_q;
   map_table_t   map_table_restore_q;
   rob_idx_t     rob_tail_restore_q;
   branch_mask_t resolve_clear_q;

   assign retire_mask = retire_fold(bs.phys_reg_retiring, bs.num_retiring_valid);

   branch_slot_alloc #(.DEPTH(DEPTH)) u_alloc (
      .busy  (valid_q),
      .grant (alloc_onehot)
   );

   assign dispatch_ready_w = ~&valid_q;
   assign bs.dispatch_ready = dispatch_ready_w;
   assign bs.dispatch_mask  = alloc_onehot;
   assign bs.branch_mask    = valid_q;

   assign res_ok  = bs.resolve_valid && is_onehot(bs.resolve_mask) && ((bs.resolve_mask & valid_q) != '0);
   assign res_mis = res_ok && bs.resolve_mispredict;
   assign res_cor = res_ok && !bs.resolve_mispredict;
   // A mispredicting branch squashes anything dispatched behind it, including this cycle's.
   assign push    = bs.dispatch_valid && dispatch_ready_w && !res_mis;

   always_comb begin
      squash        = '0;
      res_free_list = '0;
      res_map_table = '0;
      res_rob_tail  = '0;
      for (int j = 0; j < DEPTH; j++) begin
         if (valid_q[j] && (bs.resolve_mask[j] || ((slot_q[j].dep_mask & bs.resolve_mask) != '0))) begin
            squash[j] = 1'b1;
         end
         if (bs.resolve_mask[j]) begin
            res_free_list = slot_q[j].free_list;
            res_map_table = slot_q[j].map_table;
            res_rob_tail  = slot_q[j].rob_tail;
         end
      end
   end

   // The slot freed by a correct resolve is not in alloc_onehot this cycle, so set/clear never collide.
   always_comb begin
      valid_d = valid_q;
      if (res_mis) begin
         valid_d = valid_q & ~squash;
      end else begin
         if (res_cor) valid_d = valid_d & ~bs.resolve_mask;
         if (push)    valid_d = valid_d | alloc_onehot;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_q <= '0;
         for (int j = 0; j < DEPTH; j++) begin
            slot_q[j] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int j = 0; j < DEPTH; j++) begin
            if (push && alloc_onehot[j]) begin
               slot_q[j].free_list <= bs.dispatch_free_list | retire_mask;
               slot_q[j].map_table <= bs.dispatch_map_table;
               slot_q[j].rob_tail  <= bs.dispatch_rob_tail;
               slot_q[j].dep_mask  <= valid_q & ~(res_cor ? bs.resolve_mask : '0);
            end else if (valid_q[j]) begin
               slot_q[j].free_list <= slot_q[j].free_list | retire_mask;
               if (res_cor) begin
                  slot_q[j].dep_mask <= slot_q[j].dep_mask & ~bs.resolve_mask;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         restore_flag_q      <= 1'b0;
         free_list_restore_q <= '0;
         map_table_restore_q <= '0;
         rob_tail_restore_q  <= '0;
         resolve_clear_q     <= '0;
      end else begin
         restore_flag_q  <= res_mis;
         resolve_clear_q <= res_cor ? bs.resolve_mask : '0;
         if (res_mis) begin
            free_list_restore_q <= res_free_list | retire_mask;
            map_table_restore_q <= res_map_table;
            rob_tail_restore_q  <= res_rob_tail;
         end
      end
   end

   assign bs.restore_flag       = restore_flag_q;
   assign bs.free_list_restore  = free_list_restore_q;
   assign bs.map_table_restore  = map_table_restore_q;
   assign bs.rob_tail_restore   = rob_tail_restore_q;
   assign bs.resolve_clear_mask = resolve_clear_q;

`ifdef BRANCH_STACK_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         num_mispredicts <= '0;
         num_correct     <= '0;
      end else begin
         if (res_mis && (num_mispredicts != '1)) num_mispredicts <= num_mispredicts + 1'b1;
         if (res_cor && (num_correct != '1))     num_correct     <= num_correct + 1'b1;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         assert (!(bs.dispatch_valid && !dispatch_ready_w))
            else $error("branch_stack: dispatch while no slot is free");
         assert (!bs.resolve_valid || res_ok)
            else $error("branch_stack: resolve of invalid slot or non-one-hot mask");
      end
   end

endmodule

// File: tb/tb_branch_stack.sv
// tb/tb_branch_stack.sv - randomized bench for branch_stack against an age-ordered checkpoint model
module tb_branch_stack;
   import branch_stack_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   branch_stack_if bs ();

`ifdef BRANCH_STACK_STATS_EN
   logic [31:0] num_mispredicts;
   logic [31:0] num_correct;
`endif

   branch_stack dut (
      .clock (clock),
      .reset (reset),
      .bs    (bs)
`ifdef BRANCH_STACK_STATS_EN
      ,
      .num_mispredicts (num_mispredicts),
      .num_correct     (num_correct)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   // Model: slots are ordered by a dispatch sequence number; younger = larger number.
   bit          m_valid [DEPTH];
   longint      m_seq   [DEPTH];
   free_list_t  m_fl    [DEPTH];
   map_table_t  m_map   [DEPTH];
   rob_idx_t    m_tail  [DEPTH];
   longint      m_seq_ctr = 0;
   bit          m_flag;
   branch_mask_t m_clear;
   free_list_t  m_fl_r;
   map_table_t  m_map_r;
   rob_idx_t    m_tail_r;
   int unsigned m_nmis, m_ncor;
   free_list_t  m_rm;
   int          m_free, m_ri;
   longint      m_s;

   function automatic int lowest_free();
      for (int j = 0; j < DEPTH; j++) if (!m_valid[j]) return j;
      return -1;
   endfunction

   function automatic branch_mask_t mdl_mask();
      branch_mask_t m = '0;
      for (int j = 0; j < DEPTH; j++) m[j] = m_valid[j];
      return m;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock) begin
      if (!reset) begin
         for (int j = 0; j < DEPTH; j++) m_valid[j] = 1'b0;
         m_flag = 1'b0; m_clear = '0; m_fl_r = '0; m_map_r = '0; m_tail_r = '0;
         m_nmis = 0; m_ncor = 0;
      end else begin
         m_rm = '0;
         for (int i = 0; i < int'(bs.num_retiring_valid) && i < RETIRE_W; i++)
            m_rm[bs.phys_reg_retiring[i*PHYS_REG_IDX +: PHYS_REG_IDX]] = 1'b1;
         m_free = lowest_free();
         for (int j = 0; j < DEPTH; j++) if (m_valid[j]) m_fl[j] = m_fl[j] | m_rm;
         m_flag = 1'b0;
         m_clear = '0;
         m_ri = -1;
         if (bs.resolve_valid && $countones(bs.resolve_mask) == 1)
            for (int j = 0; j < DEPTH; j++) if (bs.resolve_mask[j] && m_valid[j]) m_ri = j;
         if (m_ri >= 0 && bs.resolve_mispredict) begin
            m_fl_r = m_fl[m_ri]; m_map_r = m_map[m_ri]; m_tail_r = m_tail[m_ri];
            m_flag = 1'b1;
            m_nmis++;
            m_s = m_seq[m_ri];
            for (int j = 0; j < DEPTH; j++) if (m_valid[j] && m_seq[j] >= m_s) m_valid[j] = 1'b0;
         end else begin
            if (m_ri >= 0) begin
               m_valid[m_ri] = 1'b0;
               m_clear = bs.resolve_mask;
               m_ncor++;
            end
            if (bs.dispatch_valid && m_free >= 0) begin
               m_valid[m_free] = 1'b1;
               m_seq[m_free]   = m_seq_ctr;
               m_seq_ctr++;
               m_fl[m_free]    = bs.dispatch_free_list | m_rm;
               m_map[m_free]   = bs.dispatch_map_table;
               m_tail[m_free]  = bs.dispatch_rob_tail;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         branch_mask_t gm;
         int f;
         f  = lowest_free();
         gm = (f >= 0) ? branch_mask_t'(1 << f) : '0;
         check("branch_mask", bs.branch_mask, mdl_mask());
         check("dispatch_ready", bs.dispatch_ready, (f >= 0));
         check("dispatch_mask", bs.dispatch_mask, gm);
         check("restore_flag", bs.restore_flag, m_flag);
         check("resolve_clear_mask", bs.resolve_clear_mask, m_clear);
         check("free_list_restore", bs.free_list_restore, m_fl_r);
         check("map_table_restore", bs.map_table_restore, m_map_r);
         check("rob_tail_restore", bs.rob_tail_restore, m_tail_r);
`ifdef BRANCH_STACK_STATS_EN
         check("num_mispredicts", num_mispredicts, m_nmis);
         check("num_correct", num_correct, m_ncor);
`endif
      end
   end

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
      #1;
   endtask

   task automatic idle();
      bs.dispatch_valid     = 1'b0;
      bs.resolve_valid      = 1'b0;
      bs.resolve_mask       = '0;
      bs.resolve_mispredict = 1'b0;
      bs.num_retiring_valid = '0;
      bs.phys_reg_retiring  = '0;
   endtask

   task automatic rand_dispatch();
      bs.dispatch_valid     = 1'b1;
      bs.dispatch_free_list = {$urandom, $urandom};
      bs.dispatch_map_table = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bs.dispatch_rob_tail  = rob_idx_t'($urandom_range(0, ROB_SZ - 1));
   endtask

   task automatic resolve(input int slot, input bit mis);
      bs.resolve_valid      = 1'b1;
      bs.resolve_mask       = branch_mask_t'(1 << slot);
      bs.resolve_mispredict = mis;
   endtask

   map_table_t lit_map;
   int nv, pick, k;

   initial begin
      idle();
      bs.dispatch_free_list = '0;
      bs.dispatch_map_table = '0;
      bs.dispatch_rob_tail  = '0;
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_branch_mask", bs.branch_mask, 4'b0000);
      check("rst_ready", bs.dispatch_ready, 1'b1);
      check("rst_restore_flag", bs.restore_flag, 1'b0);
      check("rst_clear", bs.resolve_clear_mask, 4'b0000);
      check("rst_fl_restore", bs.free_list_restore, 64'h0);
      reset = 1'b1;

      // fill all four slots
      for (int i = 0; i < DEPTH; i++) begin
         check("fill_grant", bs.dispatch_mask, 4'b0001 << i);
         rand_dispatch();
         tick();
      end
      idle();
      check("full_branch_mask", bs.branch_mask, 4'b1111);
      check("full_ready", bs.dispatch_ready, 1'b0);
      check("full_grant", bs.dispatch_mask, 4'b0000);
      resolve(0, 1'b1);
      tick();
      idle();
      check("flush_flag", bs.restore_flag, 1'b1);
      check("flush_mask", bs.branch_mask, 4'b0000);
      tick();
      check("flush_flag_drop", bs.restore_flag, 1'b0);

      // retire fold into a live snapshot
      rand_dispatch();
      bs.dispatch_free_list = 64'h0F;
      tick();
      idle();
      bs.num_retiring_valid = 2'd2;
      bs.phys_reg_retiring  = {6'd41, 6'd40};
      tick();
      idle();
      resolve(0, 1'b1);
      tick();
      idle();
      check("fold_flag", bs.restore_flag, 1'b1);
      check("fold_fl_restore", bs.free_list_restore, 64'h0000_0300_0000_000F);
      tick();

      // squash of younger slots on middle mispredict
      for (int i = 0; i < 3; i++) begin
         rand_dispatch();
         bs.dispatch_map_table = {32{6'(i + 7)}};
         bs.dispatch_rob_tail  = 5'(i + 10);
         tick();
      end
      idle();
      check("three_live", bs.branch_mask, 4'b0111);
      resolve(1, 1'b1);
      tick();
      idle();
      lit_map = {32{6'd8}};
      check("mid_mis_mask", bs.branch_mask, 4'b0001);
      check("mid_mis_flag", bs.restore_flag, 1'b1);
      check("mid_mis_map", bs.map_table_restore, lit_map);
      check("mid_mis_tail", bs.rob_tail_restore, 5'd11);

      // correct resolve with same-cycle dispatch
      check("cor_grant", bs.dispatch_mask, 4'b0010);
      rand_dispatch();
      resolve(0, 1'b0);
      tick();
      idle();
      check("cor_clear", bs.resolve_clear_mask, 4'b0001);
      check("cor_mask", bs.branch_mask, 4'b0010);
      tick();
      check("cor_clear_drop", bs.resolve_clear_mask, 4'b0000);

      // mispredict drops same-cycle dispatch
      check("mis_disp_grant", bs.dispatch_mask, 4'b0001);
      rand_dispatch();
      resolve(1, 1'b1);
      tick();
      idle();
      check("mis_disp_mask", bs.branch_mask, 4'b0000);
      check("mis_disp_flag", bs.restore_flag, 1'b1);
      tick();
      check("mis_disp_pulse", bs.restore_flag, 1'b0);

      // reset arriving with a mispredict suppresses the pulse
      rand_dispatch();
      tick();
      idle();
      resolve(0, 1'b1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      idle();
      check("rst_mid_flag", bs.restore_flag, 1'b0);
      check("rst_mid_mask", bs.branch_mask, 4'b0000);

      // two correct, three mispredict
      for (int i = 0; i < 5; i++) begin
         rand_dispatch();
         tick();
         idle();
         resolve(0, (i >= 2));
         tick();
         idle();
      end
`ifdef BRANCH_STACK_STATS_EN
      check("stats_mis", num_mispredicts, 32'd3);
      check("stats_cor", num_correct, 32'd2);
`endif

      // randomized legal traffic
      for (int c = 0; c < 800; c++) begin
         idle();
         if (lowest_free() >= 0 && $urandom_range(0, 99) < 55) rand_dispatch();
         bs.num_retiring_valid = 2'($urandom_range(0, RETIRE_W));
         bs.phys_reg_retiring  = retire_bus_t'($urandom);
         nv = 0;
         for (int j = 0; j < DEPTH; j++) if (m_valid[j]) nv++;
         if (nv > 0 && $urandom_range(0, 99) < 35) begin
            pick = $urandom_range(0, nv - 1);
            k = 0;
            for (int j = 0; j < DEPTH; j++) begin
               if (m_valid[j]) begin
                  if (k == pick) resolve(j, ($urandom_range(0, 99) < 30));
                  k++;
               end
            end
         end
         tick();
      end
      idle();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
